sdbp_frame_tx: RTL

Frame buffer and serializer downstream of the LED brightness generator. Captures 16-bit per-LED brightness words written over the `wtaddr`/`wtdina` port into a ping-pong buffer. On each rising edge of `sdbpflag` it swaps banks and shifts the just-completed frame out MSB-first to the MiniLED driver over a three-wire serial link (`sdclk`/`sdo`/`sdle`).

---
 rtl/sdbp_pkg.sv | 21 ++
 rtl/sdbp_frame_ram.sv | 34 +++
 rtl/sdbp_frame_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sdbp_pkg.sv
// Shared defaults, FSM state encoding and a counter-width helper for the
// sdbp frame transmitter.
package sdbp_pkg;

   localparam int NUM_LED_DEF = 360;
   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } sdbp_state_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdbp_frame_ram.sv
// Ping-pong frame store: two banks of NUM_LED words, addressed as {bank, index}.
// Synchronous write, synchronous read with one cycle of latency, no reset.
module sdbp_frame_ram import sdbp_pkg::*; #(
   parameter int NUM_LED = NUM_LED_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IDX_W   = cnt_w(NUM_LED)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              wr_bank_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              re_i,
   input  logic              rd_bank_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [2][NUM_LED];
   logic [DATA_W-1:0] rd_data_q;

   // Write port and registered read port; read data holds between reads.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
      end
      if (re_i) begin
         rd_data_q <= mem_q[rd_bank_i][rd_idx_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sdbp_frame_tx.sv
// Frame buffer and three-wire serializer for the MiniLED driver.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a sdbpflag rise; outputs low
//   LOAD  | word 0 of the read bank arrives from RAM into the shifter
//   SHIFT | bits go out MSB-first, 2*HALF_PERIOD cycles per bit
//   LATCH | sdle held high for LE_CYCLES cycles, then back to IDLE
module sdbp_frame_tx import sdbp_pkg::*; #(
   parameter int NUM_LED     = NUM_LED_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int HALF_PERIOD = 2,
   parameter int LE_CYCLES   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sdbpflag,
   input  logic              wten,
   input  logic [ADDR_W-1:0] wtaddr,
   input  logic [DATA_W-1:0] wtdina,
   output logic              sdclk,
   output logic              sdo,
   output logic              sdle,
   output logic              tx_busy,
   output logic              frame_drop
);

   localparam int IDX_W = cnt_w(NUM_LED);
   localparam int BIT_W = cnt_w(DATA_W);
   localparam int PH_W  = cnt_w(2 * HALF_PERIOD);
   localparam int LE_W  = cnt_w(LE_CYCLES);

   localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(NUM_LED - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * HALF_PERIOD - 1);
   localparam logic [PH_W-1:0]  PH_HALF   = PH_W'(HALF_PERIOD);
   localparam logic [LE_W-1:0]  LE_LAST   = LE_W'(LE_CYCLES - 1);

   sdbp_state_e       state_q, state_d;
   logic              sdbpflag_q;
   logic              wr_bank_q, wr_bank_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [LE_W-1:0]   le_cnt_q, le_cnt_d;
   logic              drop_q, drop_d;

   logic              rise;
   logic              wr_en;
   logic              rd_en;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data;

   assign rise  = sdbpflag & ~sdbpflag_q;
   assign wr_en = wten && (wtaddr < ADDR_W'(NUM_LED));

   // The read bank follows the next-state bank flag so the very first read
   // of a frame, issued on the swap edge, already targets the bank just
   // closed for writing.
   sdbp_frame_ram #(
      .NUM_LED (NUM_LED),
      .DATA_W  (DATA_W),
      .IDX_W   (IDX_W)
   ) u_ram (
      .clk       (clk),
      .we_i      (wr_en),
      .wr_bank_i (wr_bank_q),
      .wr_idx_i  (wtaddr[IDX_W-1:0]),
      .wr_data_i (wtdina),
      .re_i      (rd_en),
      .rd_bank_i (~wr_bank_d),
      .rd_idx_i  (rd_idx),
      .rd_data_o (rd_data)
   );

   // State, counters, shifter and edge-detect flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sdbpflag_q <= 1'b0;
         wr_bank_q  <= 1'b0;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         phase_q    <= '0;
         le_cnt_q   <= '0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sdbpflag_q <= sdbpflag;
         wr_bank_q  <= wr_bank_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         phase_q    <= phase_d;
         le_cnt_q   <= le_cnt_d;
         drop_q     <= drop_d;
      end
   end

   // Next-state logic: bank swap, word prefetch, bit timing and latch pulse.
   always_comb begin
      state_d    = state_q;
      wr_bank_d  = wr_bank_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      phase_d    = phase_q;
      le_cnt_d   = le_cnt_q;
      rd_en      = 1'b0;
      rd_idx     = '0;
      drop_d     = rise && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (rise) begin
               wr_bank_d = ~wr_bank_q;
               rd_en     = 1'b1;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            shreg_d    = rd_data;
            bit_cnt_d  = BIT_LAST;
            word_cnt_d = '0;
            phase_d    = '0;
            state_d    = SHIFT;
         end
         SHIFT: begin
            // Prefetch the next word early in the MSB so it is ready long
            // before the current word runs out.
            if ((bit_cnt_q == BIT_LAST) && (phase_q == '0) && (word_cnt_q != WORD_LAST)) begin
               rd_en  = 1'b1;
               rd_idx = word_cnt_q + 1'b1;
            end
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (bit_cnt_q == '0) begin
                  if (word_cnt_q == WORD_LAST) begin
                     le_cnt_d = LE_LAST;
                     state_d  = LATCH;
                  end else begin
                     shreg_d    = rd_data;
                     word_cnt_d = word_cnt_q + 1'b1;
                     bit_cnt_d  = BIT_LAST;
                  end
               end else begin
                  shreg_d   = shreg_q << 1;
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         LATCH: begin
            if (le_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               le_cnt_d = le_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode straight from reset flops so they drop the moment rst_n falls.
   assign sdclk      = (state_q == SHIFT) && (phase_q >= PH_HALF);
   assign sdo        = (state_q == SHIFT) && shreg_q[DATA_W-1];
   assign sdle       = (state_q == LATCH);
   assign tx_busy    = (state_q != IDLE);
   assign frame_drop = drop_q;

endmodule
